clock_mode_ctrl: RTL

// Mode sequencer for the multimodal clock. Debounces the raw push-buttons, runs the

---
 rtl/clock_mode_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/clock_mode_ctrl.sv
// clock_mode_ctrl: button debouncer plus CLOCK/SET/TIMER mode sequencer for the multimodal clock timer datapath.
// Ports:
//   clock_1kHz  in   sole clock (1 kHz tick)
//   resetn      in   asynchronous active-low reset
//   btn_mode    in   raw mode button (asynchronous, bouncy)
//   btn_start   in   raw start/pause button
//   btn_inc_h   in   raw hour-increment button
//   btn_inc_m   in   raw minute-increment button
//   timer_zero  in   datapath countdown value is all-zero
//   enable_swt  out  0 = clock/set datapath mode, 1 = countdown mode
//   inc_h_pulse out  one-cycle hour increment strobe
//   inc_m_pulse out  one-cycle minute increment strobe
//   count_run   out  countdown advance enable
//   alert_o     out  countdown-expired alert
//   mode_o      out  current state: CLOCK=0 SET=1 T_IDLE=2 T_RUN=3 T_PAUSE=4 T_DONE=5
// Build option: define AUTOREPEAT_EN to make a held inc button repeat in SET/T_IDLE.
module clock_mode_ctrl #(
  parameter int DEBOUNCE_MS  = 20,
  parameter int DONE_HOLD_MS = 3000,
  parameter int RPT_DELAY_MS = 500,
  parameter int RPT_RATE_MS  = 100
) (
  input  logic       clock_1kHz,
  input  logic       resetn,
  input  logic       btn_mode,
  input  logic       btn_start,
  input  logic       btn_inc_h,
  input  logic       btn_inc_m,
  input  logic       timer_zero,
  output logic       enable_swt,
  output logic       inc_h_pulse,
  output logic       inc_m_pulse,
  output logic       count_run,
  output logic       alert_o,
  output logic [2:0] mode_o
);
  // One counter width wide enough for every millisecond interval keeps all counters uniform.
  localparam int MAX_A = DEBOUNCE_MS > DONE_HOLD_MS ? DEBOUNCE_MS : DONE_HOLD_MS;
  localparam int MAX_B = RPT_DELAY_MS > RPT_RATE_MS ? RPT_DELAY_MS : RPT_RATE_MS;
  localparam int CNT_W = $clog2((MAX_A > MAX_B ? MAX_A : MAX_B) + 1);
  typedef enum logic [2:0] {
    CLOCK   = 3'd0,
    SET     = 3'd1,
    T_IDLE  = 3'd2,
    T_RUN   = 3'd3,
    T_PAUSE = 3'd4,
    T_DONE  = 3'd5
  } state_e;
  state_e                 state_q, state_d;
  logic [3:0]             btn, sync1_q, sync2_q, level_q, level_d, press;
  logic [3:0][CNT_W-1:0]  db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0]       done_cnt_q, done_cnt_d;
  logic                   done_end, inc_allow;
  logic                   enable_swt_q, enable_swt_d;
  logic                   count_run_q, count_run_d;
  logic                   alert_q, alert_d;
  logic [1:0]             inc_q, inc_d;

  // Bit order: 0 mode, 1 start, 2 inc_h, 3 inc_m.
  assign btn = {btn_inc_m, btn_inc_h, btn_start, btn_mode};

  // The counter tracks consecutive samples disagreeing with the accepted level; the
  // level flips on the DEBOUNCE_MS-th one, and a rising flip is the press event.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = (sync2_q[i] == level_q[i] || db_cnt_q[i] == CNT_W'(DEBOUNCE_MS - 1)) ? '0 : db_cnt_q[i] + 1'b1;
      level_d[i]  = (sync2_q[i] != level_q[i] && db_cnt_q[i] == CNT_W'(DEBOUNCE_MS - 1)) ? sync2_q[i] : level_q[i];
    end
    press = level_d & ~level_q;
  end

  assign done_end  = done_cnt_q == CNT_W'(DONE_HOLD_MS - 1);
  assign inc_allow = state_q == SET || state_q == T_IDLE;

  always_ff @(posedge clock_1kHz or negedge resetn)
    if (!resetn) state_q <= CLOCK;
    else         state_q <= state_d;

  // Mode press always takes priority over start; start over timer expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CLOCK:   state_d = press[0] ? SET : CLOCK;
      SET:     state_d = press[0] ? T_IDLE : SET;
      T_IDLE:  state_d = press[0] ? CLOCK : (press[1] && !timer_zero) ? T_RUN : T_IDLE;
      T_RUN:   state_d = press[0] ? CLOCK : press[1] ? T_PAUSE : timer_zero ? T_DONE : T_RUN;
      T_PAUSE: state_d = press[0] ? CLOCK : press[1] ? T_RUN : T_PAUSE;
      T_DONE:  state_d = press[0] ? CLOCK : (press[1] || done_end) ? T_IDLE : T_DONE;
      default: state_d = CLOCK;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    enable_swt_d = state_d != CLOCK && state_d != SET;
    count_run_d  = state_d == T_RUN;
    alert_d      = state_d == T_DONE;
    done_cnt_d   = (state_q == T_DONE && state_d == T_DONE) ? done_cnt_q + 1'b1 : '0;
  end

`ifdef AUTOREPEAT_EN
  logic [1:0][CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [1:0]            fire;
  // Zero means idle; a press loads 1 and the counter fires at RPT_DELAY_MS, then
  // reloads so each later fire is RPT_RATE_MS cycles apart.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      fire[j]      = rpt_cnt_q[j] == CNT_W'(RPT_DELAY_MS);
      rpt_cnt_d[j] = (!inc_allow || !level_d[j+2]) ? '0 :
                     press[j+2] ? CNT_W'(1) :
                     fire[j] ? CNT_W'(RPT_DELAY_MS - RPT_RATE_MS + 1) :
                     rpt_cnt_q[j] == '0 ? '0 : rpt_cnt_q[j] + 1'b1;
    end
    inc_d = {2{inc_allow}} & (press[3:2] | fire);
  end
  always_ff @(posedge clock_1kHz or negedge resetn)
    if (!resetn) rpt_cnt_q <= '0;
    else         rpt_cnt_q <= rpt_cnt_d;
`else
  always_comb inc_d = {2{inc_allow}} & press[3:2];
`endif

  always_ff @(posedge clock_1kHz or negedge resetn)
    if (!resetn) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      level_q      <= '0;
      db_cnt_q     <= '0;
      done_cnt_q   <= '0;
      enable_swt_q <= 1'b0;
      count_run_q  <= 1'b0;
      alert_q      <= 1'b0;
      inc_q        <= '0;
    end else begin
      sync1_q      <= btn;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      db_cnt_q     <= db_cnt_d;
      done_cnt_q   <= done_cnt_d;
      enable_swt_q <= enable_swt_d;
      count_run_q  <= count_run_d;
      alert_q      <= alert_d;
      inc_q        <= inc_d;
    end

  assign enable_swt  = enable_swt_q;
  assign count_run   = count_run_q;
  assign alert_o     = alert_q;
  assign inc_h_pulse = inc_q[0];
  assign inc_m_pulse = inc_q[1];
  assign mode_o      = state_q;
endmodule
